// File: rtl/petris_pkg.sv
// rtl/petris_pkg.sv - shared action code constants
package petris_pkg;

  localparam logic [1:0] ACT_NONE  = 2'b00;
  localparam logic [1:0] ACT_RIGHT = 2'b01;
  localparam logic [1:0] ACT_LEFT  = 2'b10;

endpackage

// File: rtl/action_queue_debouncer.sv
// rtl/action_queue_debouncer.sv - two-flop synchronizer plus counter debouncer for one button
module debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_i,
  output logic stable_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The toggle fires on the cycle the count would reach DEBOUNCE_CYCLES.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = ~stable_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/action_queue.sv
// rtl/action_queue.sv - debounced button press/auto-repeat events into a small FIFO
module action_queue
  import petris_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_RATE     = 3,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [1:0]                    actions,
  input  logic                          frame_tick,
  output logic                          action_valid,
  output logic [1:0]                    action_code,
  input  logic                          action_ready,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int RW = $clog2(REPEAT_DELAY + 1);

  logic [1:0] stable, stable_prev_q;
  logic [1:0] press, rpt_hit;
  logic       tick_q, tick_d1_q, frame_edge;

  assign frame_edge = tick_q & ~tick_d1_q;

  for (genvar b = 0; b < 2; b++) begin : g_btn
    logic          alone;
    logic          hit;
    logic [RW-1:0] rpt_q, rpt_d;

    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clock   (clock),
      .reset   (reset),
      .raw_i   (actions[b]),
      .stable_o(stable[b])
    );

    assign alone = stable[b] & ~stable[1-b];

    // Counter stays zero unless this button is the only one held; release clears it.
    always_comb begin
      rpt_d = '0;
      hit   = 1'b0;
      if (alone && stable_prev_q[b]) begin
        rpt_d = rpt_q;
        if (frame_edge) begin
          if (rpt_q == RW'(REPEAT_DELAY - 1)) begin
            hit   = 1'b1;
            rpt_d = RW'(REPEAT_DELAY - REPEAT_RATE);
          end else begin
            rpt_d = rpt_q + 1'b1;
          end
        end
      end
    end

    always_ff @(posedge clock) begin
      if (reset) rpt_q <= '0;
      else       rpt_q <= rpt_d;
    end

    assign press[b]   = alone & ~stable_prev_q[b];
    assign rpt_hit[b] = hit;
  end

  logic       ev_valid;
  logic [1:0] ev_code;

  assign ev_valid = |(press | rpt_hit);
  assign ev_code  = (press[1] | rpt_hit[1]) ? ACT_LEFT :
                    (press[0] | rpt_hit[0]) ? ACT_RIGHT : ACT_NONE;

  logic [1:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          do_push, do_pop;

  assign do_pop  = action_valid & action_ready;
  assign do_push = ev_valid & ((count_q != (PW+1)'(FIFO_DEPTH)) | do_pop);

  always_comb begin
    wr_ptr_d   = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
    overflow_d = overflow_q | (ev_valid & ~do_push);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stable_prev_q <= 2'b00;
      tick_q        <= 1'b0;
      tick_d1_q     <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
    end else begin
      stable_prev_q <= stable;
      tick_q        <= frame_tick;
      tick_d1_q     <= tick_q;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && do_push) mem_q[wr_ptr_q] <= ev_code;
  end

  assign action_valid = (count_q != '0);
  assign action_code  = action_valid ? mem_q[rd_ptr_q] : ACT_NONE;
  assign overflow     = overflow_q;
  assign fifo_count   = count_q;

endmodule
